store_buffer: RTL and testbench
===============================

# store_buffer

Store-side memory interface for the pipelined RV32I core and the write-direction counterpart of the load extractor. Accepts raw store requests from the execute stage, shifts/replicates the rs2 data onto the correct byte lanes, generates the 4-bit byte write mask, and flags misaligned stores. Aligned writes are queued in a small FIFO and drained to the data-memory write port over a valid/ready handshake. A load-address hit check lets the hazard unit stall loads that overlap a pending store.

## Interface
- DEPTH, 4, FIFO entries; a power of two, minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a request; equals !full.
- st_addr  in  32  byte address (ALU output).
- st_data  in  32  unaligned store data (rs2).
- st_size  in  2  00 = sb, 01 = sh, 10 = sw, 11 = illegal.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_we  out  4  byte write enables; bit i covers wdata[8i+7:8i].
- misaligned  out  1  one-cycle pulse for a rejected store.
- empty  out  1  no pending stores. Used for fence and MMIO ordering.
- ld_addr  in  32  address of the load in the execute stage.
- ld_hit  out  1  a pending entry has the same word address, ld_addr[31:2].

## Operation
- A request is accepted when st_valid && st_ready.
- Alignment uses lo = st_addr[1:0]:
  - sb: wdata = {4{st_data[7:0]}}, we = 4'b0001 << lo.
  - sh: wdata = {2{st_data[15:0]}}, we = 4'b0011 << lo. Legal only if lo[0] = 0.
  - sw: wdata = st_data, we = 4'b1111. Legal only if lo = 0.
- Misaligned stores include illegal sh/sw addresses and size 11.
  - The handshake still completes.
  - No entry is enqueued and memory sees no write.
  - misaligned is registered: it is high for exactly one cycle, the cycle after acceptance.
- Each FIFO entry holds {addr[31:2], wdata, we}.
- Pointers are log2(DEPTH)+1 bits wide, with a wrap bit.
  - full when the indexes match and the wrap bits differ.
  - empty when the pointers are equal.
- mem_valid = !empty. The mem_* outputs show the head entry.
  - While mem_valid is high and mem_ready is low, the payload must stay stable.
  - When empty, mem_addr, mem_wdata and mem_we are driven to 0.
- Dequeue happens on mem_valid && mem_ready.
- Enqueue and dequeue in the same cycle are legal when not full; occupancy is then unchanged.
- When full, st_ready is low even if a dequeue occurs in the same cycle. There is no ready look-ahead.
- ld_hit is combinational: the OR over valid entries of (entry.addr == ld_addr[31:2]). A store accepted in the current cycle is not included.

## Timing
- Reset values (async, while rst_n is low and until the first edge after release):
  - FIFO empty.
  - st_ready = 1, empty = 1.
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0.
  - misaligned = 0, ld_hit = 0.
- Asserting reset mid-operation discards all queued stores with no further memory write. A misaligned pulse in progress is cleared.
- Latency from acceptance to mem_valid is 1 cycle (non-bypass).
- Throughput is 1 store per cycle when mem_ready is held high.
- A misaligned request does not change occupancy.

## Configuration
- STORE_BUF_BYPASS_EN defined:
  - When the FIFO is empty, a legal request is accepted, and mem_ready = 1, the aligned store drives mem_* combinationally in the same cycle and is not enqueued. Latency is 0.
  - If mem_ready = 0, the store is enqueued normally.
  - empty stays 1 only if no entry is queued.
- STORE_BUF_BYPASS_EN undefined: every legal store goes through the FIFO, with a fixed latency of 1 cycle.

## Structure
- Shared package/defines header holds:
  - The size encodings SIZE_B, SIZE_H, SIZE_W.
  - The entry field widths and the entry bundle layout.
- Combinational sub-module store_data_align takes (addr[1:0], size, data) and returns (wdata, we, misaligned_raw).
- It is instantiated once, ahead of the FIFO. The FIFO, pointers and hit compare stay in store_buffer.

## Test plan
- sb, addr 0x1003, data 0xAABBCCDD, mem_ready = 1:
  - Next cycle: mem_addr = 0x1000, mem_wdata = 0xDDDDDDDD, mem_we = 4'b1000.
  - With bypass: the same values appear in the same cycle.
- sh, addr 0x2002, data 0x00001234 → mem_wdata = 0x12341234, mem_we = 4'b1100. Then sw at 0x2001 → misaligned pulses once, no mem write, empty stays 1.
- mem_ready = 0, issue 5 sw to 0x100 to 0x110:
  - st_ready drops after the 4th store; the 5th is stalled.
  - Raise mem_ready: writes drain in order 0x100, 0x104, 0x108, 0x10C, then 0x110, with no loss or reordering.
- Payload stability: with mem_ready toggling randomly, mem_* are unchanged between mem_valid rising and the accepting handshake.
- ld_hit: with an entry queued for 0x3004, ld_addr = 0x3007 → ld_hit = 1; ld_addr = 0x3008 → ld_hit = 0; after the entry drains → ld_hit = 0.
- Reset mid-operation: with 3 entries queued and mem_ready = 0, pulse rst_n low asynchronously (mid-cycle) → mem_valid = 0 and empty = 1 immediately, and no write occurs after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared encodings and entry layout for the RV32I store buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package store_buffer_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WADDR_W = 30;
  localparam int DATA_W  = 32;
  localparam int WE_W    = 4;

  // One queued write: word address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
    logic [WE_W-1:0]    we;
  } sb_entry_t;

endpackage

// File: rtl/store_data_align.sv
// Places rs2 store data onto byte lanes, builds the byte mask, flags bad alignment.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is used.
module store_data_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  we,
  output logic        misaligned_raw
);

  // Replicate the narrow datum across lanes so the mask alone selects the bytes.
  always_comb begin
    wdata          = '0;
    we             = '0;
    misaligned_raw = 1'b0;
    case (size)
      SIZE_B: begin
        wdata = {4{data[7:0]}};
        we    = 4'b0001 << lo;
      end
      SIZE_H: begin
        wdata          = {2{data[15:0]}};
        we             = 4'b0011 << lo;
        misaligned_raw = lo[0];
      end
      SIZE_W: begin
        wdata          = data;
        we             = 4'b1111;
        misaligned_raw = (lo != 2'b00);
      end
      default: misaligned_raw = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns stores, queues them, drains to the data-memory write port.
// Latency: 1 cycle accept-to-mem_valid; 0 with STORE_BUF_BYPASS_EN and an idle queue.
// Backpressure: st_ready = !full (no look-ahead); head payload held while mem_ready is low.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        misaligned,
  output logic        empty,
  input  logic [31:0] ld_addr,
  output logic        ld_hit
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic             misaligned_q, misaligned_d;

  logic [31:0]      al_wdata;
  logic [3:0]       al_we;
  logic             al_mis;
  sb_entry_t        new_entry;
  sb_entry_t        head_entry;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [PTR_W-1:0] count;
  logic             fifo_empty, fifo_full;
  logic             accept, legal, bypass, enq, deq;
  logic             unused_ld_lo;

  store_data_align u_align (
    .lo             (st_addr[1:0]),
    .size           (st_size),
    .data           (st_data),
    .wdata          (al_wdata),
    .we             (al_we),
    .misaligned_raw (al_mis)
  );

  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign st_ready   = !fifo_full;
  assign empty      = fifo_empty;
  assign misaligned = misaligned_q;

  assign accept = st_valid && st_ready;
  assign legal  = accept && !al_mis;

`ifdef STORE_BUF_BYPASS_EN
  // An idle queue with a ready memory lets the store go straight through.
  assign bypass = fifo_empty && legal && mem_ready;
`else
  assign bypass = 1'b0;
`endif

  assign enq = legal && !bypass;
  assign deq = !fifo_empty && mem_ready;

  assign new_entry.waddr = st_addr[31:2];
  assign new_entry.wdata = al_wdata;
  assign new_entry.we    = al_we;
  assign head_entry      = entries_q[rd_idx];

  // Byte offset of a load is irrelevant to the word-granular hit check.
  assign unused_ld_lo = ^ld_addr[1:0];

  // Present the head entry, the bypassed store, or zeros when nothing is pending.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (!fifo_empty) begin
      mem_valid = 1'b1;
      mem_addr  = {head_entry.waddr, 2'b00};
      mem_wdata = head_entry.wdata;
      mem_we    = head_entry.we;
    end else if (bypass) begin
      mem_valid = 1'b1;
      mem_addr  = {new_entry.waddr, 2'b00};
      mem_wdata = new_entry.wdata;
      mem_we    = new_entry.we;
    end
  end

  // Word-address match against every occupied slot, i.e. offsets below the occupancy.
  always_comb begin
    logic [IDX_W-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = IDX_W'(i) - rd_idx;
      if (({1'b0, off} < count) && (entries_q[i].waddr == ld_addr[31:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  // Next-state for pointers, storage and the misaligned pulse.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    entries_d    = entries_q;
    misaligned_d = accept && al_mis;
    if (enq) begin
      entries_d[wr_idx] = new_entry;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers; reset discards every queued store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      misaligned_q <= misaligned_d;
      entries_q    <= entries_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer with a queue-based reference model.
// Expectations are pushed at acceptance; a monitor pops them at each memory handshake.
// Build with STORE_BUF_BYPASS_EN to exercise the zero-latency path.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        misaligned, empty;
  logic [31:0] ld_addr;
  logic        ld_hit;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .misaligned(misaligned), .empty(empty),
    .ld_addr(ld_addr), .ld_hit(ld_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   exp_mis_next = 0;
  bit   exp_mis_cur  = 0;
  bit   stall_seen   = 0;
  exp_t stall_val;
  bit   rnd_on = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  // Reference alignment from the architectural rules; returns 1 if the store is legal.
  function automatic bit model_align(input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] d, output exp_t e);
    int lane;
    bit ok;
    lane    = int'(a % 4);
    e.addr  = a - 32'(lane);
    e.wdata = 0;
    e.we    = 0;
    ok      = 0;
    case (sz)
      2'd0: begin ok = 1;              e.wdata = d[7:0]  * 32'h01010101; e.we = 4'(1 << lane); end
      2'd1: begin ok = (lane % 2 == 0); e.wdata = d[15:0] * 32'h00010001; e.we = 4'(3 << lane); end
      2'd2: begin ok = (lane == 0);     e.wdata = d;                      e.we = 4'hF;          end
      default: ok = 0;
    endcase
    return ok;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    foreach (sb_q[i]) if ((sb_q[i].addr >> 2) == (a >> 2)) return 1;
    return 0;
  endfunction

  // Acceptance side: status checks against model occupancy, then record the request.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_mis_next = 0;
    end else begin
      exp_t e;
      check1("st_ready", st_ready, sb_q.size() < DEPTH);
      check1("empty", empty, sb_q.size() == 0);
      check1("ld_hit", ld_hit, model_hit(ld_addr));
      exp_mis_next = 0;
      if (st_valid && st_ready) begin
        if (model_align(st_size, st_addr, st_data, e)) sb_q.push_back(e);
        else exp_mis_next = 1;
      end
    end
  end

  // Monitor: pops expected writes on each handshake, checks pulse and payload stability.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      stall_seen  = 0;
      exp_mis_cur = 0;
    end else begin
      check1("misaligned", misaligned, exp_mis_cur);
      exp_mis_cur = exp_mis_next;
      if (stall_seen) begin
        check1("stall_valid", mem_valid, 1'b1);
        check32("stall_addr", mem_addr, stall_val.addr);
        check32("stall_wdata", mem_wdata, stall_val.wdata);
        check32("stall_we", {28'd0, mem_we}, {28'd0, stall_val.we});
      end
      if (mem_valid) begin
        check1("write_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          check32("mem_addr", mem_addr, sb_q[0].addr);
          check32("mem_wdata", mem_wdata, sb_q[0].wdata);
          check32("mem_we", {28'd0, mem_we}, {28'd0, sb_q[0].we});
          if (mem_ready) void'(sb_q.pop_front());
        end
      end else begin
        check32("idle_payload", mem_addr | mem_wdata | {28'd0, mem_we}, 32'd0);
      end
      stall_seen      = mem_valid && !mem_ready;
      stall_val.addr  = mem_addr;
      stall_val.wdata = mem_wdata;
      stall_val.we    = mem_we;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a request until the buffer takes it; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bit done;
    done     = 0;
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (st_ready) done = 1;
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout addr=0x%08h", a);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = SIZE_W;
    mem_ready = 1'b0;
    ld_addr   = '0;

    // Reset values before any clock edge.
    #2;
    check1("rst_st_ready", st_ready, 1'b1);
    check1("rst_empty", empty, 1'b1);
    check1("rst_mem_valid", mem_valid, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check1("rst_misaligned", misaligned, 1'b0);
    check1("rst_ld_hit", ld_hit, 1'b0);
    #10 rst_n = 1'b1;
    idle(1);

    // Byte store to the top lane.
    mem_ready = 1'b1;
    send(SIZE_B, 32'h0000_1003, 32'hAABB_CCDD);
`ifdef STORE_BUF_BYPASS_EN
    check1("sb_bypassed", mem_valid, 1'b0);
`else
    check1("sb_latency_valid", mem_valid, 1'b1);
    check32("sb_addr", mem_addr, 32'h0000_1000);
    check32("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    check32("sb_we", {28'd0, mem_we}, 32'h8);
`endif
    idle(3);

    // Halfword to the upper half, then a misaligned word.
    send(SIZE_H, 32'h0000_2002, 32'h0000_1234);
`ifndef STORE_BUF_BYPASS_EN
    check32("sh_wdata", mem_wdata, 32'h1234_1234);
    check32("sh_we", {28'd0, mem_we}, 32'hC);
`endif
    idle(2);
    send(SIZE_W, 32'h0000_2001, 32'hDEAD_BEEF);
    check1("mis_pulse", misaligned, 1'b1);
    check1("mis_no_write", mem_valid, 1'b0);
    idle(1);
    check1("mis_pulse_end", misaligned, 1'b0);
    check1("mis_empty", empty, 1'b1);

    // Fill with the memory stalled, fifth store waits, then drain in order.
    mem_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(SIZE_W, 32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
      end
      begin
        idle(8);
        check1("full_st_ready", st_ready, 1'b0);
        check32("full_head", mem_addr, 32'h0000_0100);
        mem_ready = 1'b1;
      end
    join
    idle(8);

    // Load-hit check on a single pending word.
    mem_ready = 1'b0;
    send(SIZE_W, 32'h0000_3004, 32'h5555_AAAA);
    ld_addr = 32'h0000_3007;
    #1 check1("ld_hit_same_word", ld_hit, 1'b1);
    ld_addr = 32'h0000_3008;
    #1 check1("ld_hit_next_word", ld_hit, 1'b0);
    mem_ready = 1'b1;
    ld_addr   = 32'h0000_3004;
    idle(3);
    check1("ld_hit_drained", ld_hit, 1'b0);

    // Asynchronous reset with three stores pending.
    mem_ready = 1'b0;
    send(SIZE_W, 32'h400, 32'h1);
    send(SIZE_W, 32'h404, 32'h2);
    send(SIZE_W, 32'h408, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_mem_valid", mem_valid, 1'b0);
    check1("arst_empty", empty, 1'b1);
    check1("arst_st_ready", st_ready, 1'b1);
    sb_q.delete();
    exp_mis_next = 0;
    exp_mis_cur  = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    idle(6);

    // Random traffic with a random memory-ready pattern.
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 mem_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 300; n++) begin
          ld_addr = 32'h5000 + 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) idle(1);
          else send(2'($urandom_range(0, 3)), 32'h5000 + 32'($urandom_range(0, 15)), $urandom);
        end
        rnd_on = 0;
      end
    join
    mem_ready = 1'b1;
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) idle(1);
    check32("final_drain", 32'(sb_q.size()), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
